// File: rtl/inv_key_schedule.sv
// Reverse AES-128 key expander: takes the round-10 key and emits round keys
// 10 down to 0, one per accepted transfer, using four forward S-box cells.

module sbox (
  input  logic [7:0] value,
  output logic [7:0] subst
);

  // GF(2^8) multiply modulo x^8+x^4+x^3+x+1.
  function automatic logic [7:0] gfMul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  logic [7:0] x2, x3, x6, x12, x15, x30, x60, x120, x240, inv;

  // Multiplicative inverse as x^254 (maps 0 to 0), then the affine transform.
  always_comb begin
    x2    = gfMul(value, value);
    x3    = gfMul(x2, value);
    x6    = gfMul(x3, x3);
    x12   = gfMul(x6, x6);
    x15   = gfMul(x12, x3);
    x30   = gfMul(x15, x15);
    x60   = gfMul(x30, x30);
    x120  = gfMul(x60, x60);
    x240  = gfMul(x120, x120);
    inv   = gfMul(gfMul(x240, x12), x2);
    subst = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
          ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  end

endmodule

module inv_key_schedule #(
  parameter int NR = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         validIn,
  input  logic [127:0] lastKey,
  output logic         ready,
  output logic         validOut,
  input  logic         outReady,
  output logic [127:0] roundKey,
  output logic [3:0]   roundNum,
  output logic         done
);

  typedef enum logic {IDLE, EMIT} stateT;

  stateT        state, nextState;
  logic [127:0] keyNext, prevKey;
  logic [3:0]   numNext;
  logic         doneNext;
  logic [31:0]  w0n, w1n, w2n, w3n, rotWord, subWord;
  logic [7:0]   rcon;

  function automatic logic [7:0] rconOf(input logic [3:0] i);
    case (i)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  // One inverse schedule step straight from the roundKey register.
  always_comb begin
    w3n     = roundKey[31:0]  ^ roundKey[63:32];
    w2n     = roundKey[63:32] ^ roundKey[95:64];
    w1n     = roundKey[95:64] ^ roundKey[127:96];
    rotWord = {w3n[23:0], w3n[31:24]};
    rcon    = rconOf(roundNum);
    w0n     = roundKey[127:96] ^ subWord ^ {rcon, 24'h000000};
    prevKey = {w0n, w1n, w2n, w3n};
  end

  sbox sb0 (.value(rotWord[31:24]), .subst(subWord[31:24]));
  sbox sb1 (.value(rotWord[23:16]), .subst(subWord[23:16]));
  sbox sb2 (.value(rotWord[15:8]),  .subst(subWord[15:8]));
  sbox sb3 (.value(rotWord[7:0]),   .subst(subWord[7:0]));

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= nextState;
  end

  // The walk ends only when the round-0 key is actually accepted.
  always_comb begin
    nextState = state;
    case (state)
      IDLE: if (validIn) nextState = EMIT;
      EMIT: if (outReady && roundNum == 4'd0) nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  always_comb begin
    keyNext  = roundKey;
    numNext  = roundNum;
    doneNext = 1'b0;
    case (state)
      IDLE: begin
        if (validIn) begin
          keyNext = lastKey;
          numNext = 4'(NR);
        end
      end
      EMIT: begin
        if (outReady) begin
          if (roundNum != 4'd0) begin
            keyNext = prevKey;
            numNext = roundNum - 4'd1;
          end else begin
            doneNext = 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      roundKey <= '0;
      roundNum <= '0;
      done     <= 1'b0;
    end else begin
      roundKey <= keyNext;
      roundNum <= numNext;
      done     <= doneNext;
    end
  end

  // Both flags decode the one-bit state flop directly.
  assign ready    = (state == IDLE);
  assign validOut = (state == EMIT);

endmodule

// File: doc/inv_key_schedule.md
Name: inv_key_schedule

Overview:
- Reverse-direction AES-128 key expander for the decrypt datapath.
- Accepts the final (round-10) round key and walks the schedule backward, one round per cycle, emitting round keys 10, 9, …, 0 in the order the inverse cipher consumes them.
- Round 0 equals the original cipher key.
- Reuses the existing 8-bit `sbox` cell (x4) for SubWord and uses the same Rcon table as the forward schedule.

Parameters:
- NR, 10, number of rounds; fixed at 10 for AES-128, no other value supported.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous active-high reset
- validIn  input  1  start request; lastKey is sampled when validIn=1 and ready=1
- lastKey  input  128  round-10 key, word w0 in [127:96], w3 in [31:0]
- ready  output  1  high in IDLE; block can accept validIn
- validOut  output  1  roundKey/roundNum hold a valid key
- outReady  input  1  consumer accepts the current key when validOut=1 and outReady=1
- roundKey  output  128  current round key, same word packing as lastKey
- roundNum  output  4  round index of roundKey, 10 down to 0
- done  output  1  one-cycle pulse after round 0 is accepted

Behaviour:
- Reset (rst=1 at clk edge, any state): state=IDLE, ready=1, validOut=0, done=0, roundKey=0, roundNum=0. Reset mid-walk abandons the walk with no further outputs.
- States: IDLE, EMIT.
- IDLE → EMIT on validIn=1. Next cycle: roundKey=lastKey, roundNum=10, validOut=1, ready=0. Latency from validIn to first key valid is 1 cycle.
- EMIT, transfer (validOut & outReady):
  - If roundNum>0: roundKey ← prev(roundKey, roundNum), roundNum ← roundNum−1, validOut stays 1.
  - If roundNum=0: go to IDLE, validOut ← 0, done ← 1 for exactly one cycle, ready ← 1.
- EMIT with outReady=0: roundKey and roundNum hold. Keys are never skipped or repeated.
- validIn while in EMIT is ignored. Only a validIn seen with ready=1 starts a walk. A validIn in the same cycle as done=1 is accepted, because ready=1 then.
- Inverse step prev(K,i), with K={w0,w1,w2,w3}:
  - w3' = w3^w2
  - w2' = w2^w1
  - w1' = w1^w0
  - w0' = w0 ^ SubWord(RotWord(w3')) ^ Rcon(i)
  - RotWord(x) = {x[23:0],x[31:24]}. SubWord applies the forward sbox bytewise.
  - Rcon(i) for i=1..10: 01,02,04,08,10,20,40,80,1b,36, in byte [31:24] with the low 24 bits zero. Rcon(i)=0 for any other i.
- One inverse step per cycle: the combinational path runs from the roundKey register through the 4 sbox instances and XOR into the roundKey register. No multicycle paths.
- Minimum walk with outReady tied high: 11 consecutive validOut cycles, then done. validIn-to-done is 12 cycles.
- All outputs are registered. roundKey is don't-care-free: it holds its last value (round 0) after done until the next start.

Test Plan:
- FIPS-197 A.1: validIn with lastKey=d014f9a8c9ee2589e13f0cc8b6630ca6, outReady=1.
  - Required keys: roundNum 10 = d014f9a8c9ee2589e13f0cc8b6630ca6, roundNum 9 = ac7766f319fadc2128d12941575c006e, …, roundNum 1 = a0fafe1788542cb123a339392a6c7605, roundNum 0 = 2b7e151628aed2a6abf7158809cf4f3c.
  - Required timing: done one cycle after the round-0 transfer.
- Backpressure: same stimulus, toggle outReady pseudo-randomly → identical 11-key sequence, roundKey and roundNum stable whenever validOut & !outReady, done only after the round-0 transfer.
- Ignored start: assert validIn with a different lastKey at roundNum=6 → sequence unaffected, ready=0 throughout EMIT.
- Reset mid-walk: rst=1 at roundNum=4 → next cycle validOut=0, done=0, ready=1, roundKey=0. A fresh validIn restarts cleanly at roundNum=10.
- Back-to-back starts: validIn held high continuously → second walk starts in the cycle done=1. First key of the second walk appears 1 cycle later, with no lost or duplicated keys.
- Cross-check: for random 128-bit keys, expand forward with the existing forward key-expansion round module (rnum 1..10) and feed the result as lastKey → emitted roundNum-0 key equals the original key, and every intermediate key matches the forward chain.
